param_countdown_timer: RTL
==========================

Name: param_countdown_timer

Overview:
Parametrised countdown timer, successor to the lab's fixed 10-bit seconds counter. Loads a start value on a Start pulse and decrements once per prescaled tick. Pulses Done at terminal count. Adds pause, abort and restart-on-Start behaviour, and optional auto-reload. Sits between the control FSM (Start/Pause/Abort) and the display/compare logic that reads Count.

Parameters:
WIDTH, 10, width of the count value and LoadValue
PRESCALE, 1, Clock cycles per count decrement; legal range >= 1; 1 = decrement every cycle
PS_WIDTH, max(1, clog2(PRESCALE)), prescaler counter width; derived, never overridden

Ports:
Clock  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  single-cycle request: latch LoadValue and begin counting
LoadValue  input  WIDTH  initial count, sampled only on the edge where Start is accepted
Pause  input  1  level; while high in RUN, prescaler and Count freeze
Abort  input  1  single-cycle request: stop, clear Count, no Done
Count  output  WIDTH  current remaining count
Busy  output  1  high in RUN or PAUSED
Done  output  1  one-cycle pulse at terminal count

Behaviour:
- Reset (Reset=0, async): state IDLE, Count=0, prescaler=0, Busy=0, Done=0, latched reload value=0.
- States: IDLE, RUN, PAUSED. Done is a registered pulse, not a state.
- Input priority per edge: Abort > Start > Pause > normal count.
- IDLE + Start: Count<=LoadValue, prescaler<=0, go RUN. If LoadValue==0: Done=1 next cycle, stay IDLE, Count=0.
- RUN: prescaler increments each edge; at PRESCALE-1 it wraps to 0 and Count decrements by 1 (tick).
- Terminal count: a tick with Count==1 sets Count<=0, Done<=1 for exactly one cycle and state<=IDLE on the same edge. Count never underflows.
- Latency: Start sampled at edge k -> Count==0 and Done==1 after edge k+LoadValue*PRESCALE.
- Pause=1 in RUN: go PAUSED; Count and prescaler hold. Pause=0 in PAUSED: return RUN and resume from the frozen prescaler value, so no tick is lost or duplicated.
- Pause in IDLE: ignored.
- Start in RUN or PAUSED: restart. Reload LoadValue, clear prescaler, go RUN even if Pause is high. Pause takes effect on the next edge.
- Abort in any state: Count<=0, prescaler<=0, state IDLE, Done stays 0.
- Start and Abort on the same edge: Abort wins.
- Start on the same edge as terminal count: Start wins. Count<=LoadValue, Done stays 0.
- Busy is a registered output, equal to (state != IDLE).
- Reset asserted mid-count: all outputs return to reset values immediately; no Done.

Optional Feature:
Macro: PARAM_COUNTDOWN_TIMER_AUTO_RELOAD_EN.
- Defined: adds input port Repeat (1 bit).
  - If Repeat=1 at terminal tick: Done pulses, Count<=latched LoadValue, prescaler<=0, state stays RUN.
  - Continuous period is LoadValue*PRESCALE cycles.
  - Abort is the only exit.
  - If Repeat=0, behaviour is one-shot.
- Undefined: no Repeat port; always one-shot as above.

Decomposition:
- Package timer_pkg:
  - state enum (IDLE, RUN, PAUSED)
  - localparam helper for PS_WIDTH
  - shared count-width constant COUNT_W_DEFAULT=10
- One sub-module, tick_gen:
  - parametrised by PRESCALE
  - inputs: enable, clear
  - output: one-cycle tick at wrap
  - holds its value when enable=0

Test Plan:
- Reset low 2 cycles then high; WIDTH=10, PRESCALE=1, LoadValue=7, Start pulse -> Count 7,6,...,0 on successive edges; Done high exactly 1 cycle with Count==0 after 7 edges; Busy falls on the same edge.
- PRESCALE=4, LoadValue=3, Start -> Count decrements every 4 cycles; Done exactly 12 cycles after the Start edge.
- LoadValue=10, Pause high for 5 cycles after Count reaches 6 -> Count holds at 6, Busy stays 1; total Start-to-Done = 15 cycles.
- LoadValue=20, Abort when Count==12 -> Count=0, Busy=0, no Done pulse; Abort+Start on the same edge -> IDLE, Count=0.
- LoadValue=5 running, Start with LoadValue=9 at Count==2 -> Count=9, no Done for the first run; Done 9 cycles later. LoadValue=0 Start -> Done next cycle, Busy never high.
- (macro defined) Repeat=1, LoadValue=3, PRESCALE=1 -> Done pulses every 3 cycles for 4 periods; Abort stops; Reset mid-run clears everything asynchronously.

Source files
------------

// File: rtl/param_countdown_timer_pkg.sv
// Shared types and constants for the countdown timer (package timer_pkg).
package timer_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

   localparam int unsigned COUNT_W_DEFAULT = 10;

   // Prescaler counter width; a prescale of 1 still needs one bit.
   function automatic int unsigned ps_width(input int unsigned prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction

endpackage

// File: rtl/param_countdown_timer_tick_gen.sv
// Prescaler: emits a one-cycle tick each time the counter wraps at PRESCALE-1.
module tick_gen
   import timer_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic Clock,
   input  logic Reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int unsigned PS_WIDTH = ps_width(PRESCALE);
   localparam logic [PS_WIDTH-1:0] LAST = PS_WIDTH'(PRESCALE - 1);

   logic [PS_WIDTH-1:0] cnt;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign tick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/param_countdown_timer.sv
// Parametrised countdown timer with pause, abort and restart-on-Start.
// Optional auto-reload (Repeat port) under PARAM_COUNTDOWN_TIMER_AUTO_RELOAD_EN.
module param_countdown_timer
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH    = COUNT_W_DEFAULT,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] LoadValue,
   input  logic             Pause,
   input  logic             Abort,
`ifdef PARAM_COUNTDOWN_TIMER_AUTO_RELOAD_EN
   input  logic             Repeat,
`endif
   output logic [WIDTH-1:0] Count,
   output logic             Busy,
   output logic             Done
);

   state_t           state, state_n;
   logic [WIDTH-1:0] count_n, reload, reload_n;
   logic             done_n, ps_en, ps_clr, tick, rep;

`ifdef PARAM_COUNTDOWN_TIMER_AUTO_RELOAD_EN
   assign rep = Repeat;
`else
   assign rep = 1'b0;
`endif

   tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .Clock  (Clock),
      .Reset  (Reset),
      .enable (ps_en),
      .clear  (ps_clr),
      .tick   (tick)
   );

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state  <= IDLE;
         Count  <= '0;
         reload <= '0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
      end else begin
         state  <= state_n;
         Count  <= count_n;
         reload <= reload_n;
         Busy   <= (state_n != IDLE);
         Done   <= done_n;
      end
   end

   always_comb begin
      state_n  = state;
      count_n  = Count;
      reload_n = reload;
      done_n   = 1'b0;
      ps_en    = 1'b0;
      ps_clr   = 1'b0;
      if (Abort) begin
         state_n = IDLE;
         count_n = '0;
         ps_clr  = 1'b1;
      end else if (Start) begin
         reload_n = LoadValue;
         ps_clr   = 1'b1;
         if (LoadValue == '0) begin
            state_n = IDLE;
            count_n = '0;
            done_n  = 1'b1;
         end else begin
            state_n = RUN;
            count_n = LoadValue;
         end
      end else if (state != IDLE) begin
         // The edge that leaves PAUSED also counts, so a pause costs exactly its length.
         if (Pause) begin
            state_n = PAUSED;
         end else begin
            state_n = RUN;
            ps_en   = 1'b1;
            if (tick) begin
               if (Count == WIDTH'(1)) begin
                  done_n = 1'b1;
                  if (rep) begin
                     count_n = reload;
                  end else begin
                     count_n = '0;
                     state_n = IDLE;
                  end
               end else begin
                  count_n = Count - 1'b1;
               end
            end
         end
      end
   end

endmodule
